mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; one clock; reset is synchronous and active-low.
REQ-003 SHALL have port reset_n, input, 1, synchronous active-low reset sampled on the rising clk edge.
REQ-004 SHALL have port start_execute, input, 1, a HI/LO-class instruction is in execute.
REQ-005 SHALL have port op_execute, input, 3, operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have port flush_execute, input, 1, abort any in-flight operation.
REQ-007 SHALL have ports src_A_ALU_execute and src_B_ALU_execute, input, 32 each, the forwarded operands.
REQ-008 SHALL have port busy, output, 1, high when not IDLE; the hazard unit stalls on it.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse in FIXUP.
REQ-010 SHALL have ports HI_output and LO_output, output, 32 each, the architected HI and LO registers.

Function
REQ-011 SHALL implement the FSM states IDLE, ITER and FIXUP; busy SHALL equal (state != IDLE) and SHALL be registered.
REQ-012 SHALL accept a start only in IDLE; start_execute while busy SHALL be ignored.
REQ-013 MTHI/MTLO accepted in IDLE SHALL write src_A into HI or LO respectively, visible the next cycle, with no state change and done=0.
REQ-014 For MULT/DIV accepted in cycle N, ITER SHALL occupy cycles N+1..N+32 (6-bit counter, 0..31) and FIXUP cycle N+33; new HI/LO SHALL be visible from N+34.
REQ-015 MULT/MULTU SHALL use iterative shift-add on magnitudes with a 64-bit accumulator; HI SHALL receive product[63:32] and LO product[31:0].
REQ-016 DIV/DIVU SHALL use iterative restoring division on magnitudes; LO SHALL receive the quotient and HI the remainder.
REQ-017 In signed ops, FIXUP SHALL negate the quotient or product when operand signs differ, and SHALL give the remainder the dividend's sign; all arithmetic wraps modulo 2^32 (0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0).
REQ-018 A divisor equal to 0 SHALL go IDLE->FIXUP directly, write HI=src_A and LO=0xFFFFFFFF, and pulse done.
REQ-019 flush_execute SHALL force IDLE next cycle with HI/LO unchanged; flush together with start in IDLE SHALL accept nothing; flush in FIXUP SHALL suppress the HI/LO write and done.
REQ-020 Operands SHALL be captured at accept; later changes on src_A/src_B SHALL have no effect.

Reset
REQ-021 reset_n=0 SHALL set state=IDLE, HI=0, LO=0, the counter and accumulators to 0, and busy=0 and done=0 next cycle, including when asserted mid-operation.

Configuration
REQ-022 With MULT_DIV_FAST_MULT_EN defined, MULT/MULTU SHALL compute a single-cycle 64-bit product and go IDLE->FIXUP (result visible at N+2).
REQ-023 Without MULT_DIV_FAST_MULT_EN, multiplies SHALL use the iterative path of REQ-014; division is iterative in both cases.

Structure
REQ-024 Package mult_div_pkg SHALL hold the op_execute encoding enum, the FSM state enum, ITER_COUNT=32 and the DIV_ZERO_LO=32'hFFFFFFFF constant.
REQ-025 The single restoring-division step SHALL be a combinational sub-module named div_restore_step, instantiated once.

Verification
REQ-026 MULT with 0xFFFFFFFF and 0x00000002 SHALL give HI=0xFFFFFFFF and LO=0xFFFFFFFE, with busy high for 33 cycles and done at N+33.
REQ-027 MULTU with the same operands SHALL give HI=0x00000001 and LO=0xFFFFFFFE; with the macro defined, done SHALL occur at N+1.
REQ-028 DIV with 0xFFFFFFF9 (-7) and 0x00000002 SHALL give LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIV with 0x80000000 and 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-029 DIVU with 0x00000064 and 0 SHALL give HI=0x00000064 and LO=0xFFFFFFFF, with done at N+1.
REQ-030 Flush at ITER cycle 10 SHALL leave HI/LO unchanged with no done; reset_n=0 mid-DIV SHALL give HI=LO=0, busy=0; MTLO 0x12345678 SHALL leave LO=0x12345678 next cycle.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mult_div_pkg;

    localparam int          ITER_COUNT  = 32;
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FIXUP = 2'd2
    } md_state_e;

    // Two's-complement magnitude; 0x80000000 stays 0x80000000 and reads as unsigned 2^31.
    function automatic logic [31:0] absVal(input logic [31:0] v, input logic signedOp);
        return (signedOp && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_restore_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         dividendBit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         quotBit_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted   = {rem_i, dividendBit_i};
    assign diff      = shifted - {1'b0, divisor_i};
    // No borrow out of the subtraction means the divisor fits.
    assign quotBit_o = ~diff[W];
    assign rem_o     = quotBit_o ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (IDLE -> ITER x32 -> FIXUP).
// Define MULT_DIV_FAST_MULT_EN to replace the iterative multiply with a single-cycle product.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_execute,
    input  logic [2:0]            op_execute,
    input  logic                  flush_execute,
    input  logic [DATA_WIDTH-1:0] src_A_ALU_execute,
    input  logic [DATA_WIDTH-1:0] src_B_ALU_execute,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] HI_output,
    output logic [DATA_WIDTH-1:0] LO_output
);

    localparam int W = DATA_WIDTH;

    md_state_e      state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opB_q, opB_d;
    logic           isMult_q, isMult_d;
    logic           negRes_q, negRes_d;
    logic           negRem_q, negRem_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic           signedOp;
    logic [W-1:0]   magA, magB;
    logic [W:0]     multSum;
    logic [W-1:0]   remNext;
    logic           quotBit;
    logic [2*W-1:0] accNeg;
    logic [W-1:0]   remNeg;

    assign signedOp = (op_execute == OP_MULT) || (op_execute == OP_DIV);
    assign magA     = absVal(src_A_ALU_execute, signedOp);
    assign magB     = absVal(src_B_ALU_execute, signedOp);

    // Multiply keeps the multiplier in acc[W-1:0] and shifts the partial product down into it.
    assign multSum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opB_q} : '0);
    assign accNeg   = -acc_q;
    assign remNeg   = -acc_q[2*W-1:W];

    div_restore_step #(.W(W)) u_divStep (
        .rem_i         (acc_q[2*W-1:W]),
        .dividendBit_i (acc_q[W-1]),
        .divisor_i     (opB_q),
        .rem_o         (remNext),
        .quotBit_o     (quotBit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opB_d    = opB_q;
        isMult_d = isMult_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_execute && !flush_execute) begin
                    case (op_execute)
                        OP_MTHI: hi_d = src_A_ALU_execute;
                        OP_MTLO: lo_d = src_A_ALU_execute;
                        OP_MULT, OP_MULTU: begin
                            isMult_d = 1'b1;
                            negRes_d = signedOp & (src_A_ALU_execute[W-1] ^ src_B_ALU_execute[W-1]);
                            negRem_d = 1'b0;
                            cnt_d    = '0;
`ifdef MULT_DIV_FAST_MULT_EN
                            acc_d    = {{W{1'b0}}, magA} * {{W{1'b0}}, magB};
                            state_d  = FIXUP;
`else
                            acc_d    = {{W{1'b0}}, magB};
                            opB_d    = magA;
                            state_d  = ITER;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            isMult_d = 1'b0;
                            cnt_d    = '0;
                            if (src_B_ALU_execute == '0) begin
                                acc_d    = {src_A_ALU_execute, DIV_ZERO_LO};
                                negRes_d = 1'b0;
                                negRem_d = 1'b0;
                                state_d  = FIXUP;
                            end else begin
                                acc_d    = {{W{1'b0}}, magA};
                                opB_d    = magB;
                                negRes_d = signedOp & (src_A_ALU_execute[W-1] ^ src_B_ALU_execute[W-1]);
                                negRem_d = signedOp & src_A_ALU_execute[W-1];
                                state_d  = ITER;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ITER: begin
                cnt_d = cnt_q + 6'd1;
                if (isMult_q) acc_d = {multSum, acc_q[W-1:1]};
                else          acc_d = {remNext, acc_q[W-2:0], quotBit};
                if (cnt_q == 6'(ITER_COUNT - 1)) state_d = FIXUP;
            end
            FIXUP: begin
                done    = 1'b1;
                state_d = IDLE;
                // Low half of a 2W-bit negation equals the W-bit negation of the quotient.
                lo_d    = negRes_q ? accNeg[W-1:0] : acc_q[W-1:0];
                if (isMult_q) hi_d = negRes_q ? accNeg[2*W-1:W] : acc_q[2*W-1:W];
                else          hi_d = negRem_q ? remNeg : acc_q[2*W-1:W];
            end
            default: state_d = IDLE;
        endcase

        if (flush_execute) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opB_q    <= '0;
            isMult_q <= 1'b0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opB_q    <= opB_d;
            isMult_q <= isMult_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign HI_output = hi_q;
    assign LO_output = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written flush/reset sequences.
module tb_mult_div_unit;
    import mult_div_pkg::*;

`ifdef MULT_DIV_FAST_MULT_EN
    localparam int MULT_LAT = 1;
`else
    localparam int MULT_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  opIn;
    logic        flush;
    logic [31:0] srcA, srcB;
    logic        busy, done;
    logic [31:0] hiOut, loOut;

    int passCount = 0;
    int totalCount = 0;
    logic [31:0] mHi, mLo;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start_execute     (start),
        .op_execute        (opIn),
        .flush_execute     (flush),
        .src_A_ALU_execute (srcA),
        .src_B_ALU_execute (srcB),
        .busy              (busy),
        .done              (done),
        .HI_output         (hiOut),
        .LO_output         (loOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expLat;
        string       name;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model from plain arithmetic; lat is the cycle of done after accept (0 = none).
    function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] hiIn, input logic [31:0] loIn,
                                     output logic [31:0] hiOut_m, output logic [31:0] loOut_m,
                                     output int lat);
        longint sa, sb, sp;
        logic [63:0] up;
        hiOut_m = hiIn;
        loOut_m = loIn;
        lat     = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  begin sp = sa * sb; up = sp; hiOut_m = up[63:32]; loOut_m = up[31:0]; lat = MULT_LAT; end
            OP_MULTU: begin up = {32'b0, a} * {32'b0, b}; hiOut_m = up[63:32]; loOut_m = up[31:0]; lat = MULT_LAT; end
            OP_DIV: begin
                if (b == 0) begin hiOut_m = a; loOut_m = 32'hFFFFFFFF; lat = 1; end
                else begin
                    sp = sa / sb; up = sp; loOut_m = up[31:0];
                    sp = sa % sb; up = sp; hiOut_m = up[31:0];
                    lat = DIV_LAT;
                end
            end
            OP_DIVU: begin
                if (b == 0) begin hiOut_m = a; loOut_m = 32'hFFFFFFFF; lat = 1; end
                else begin loOut_m = a / b; hiOut_m = a % b; lat = DIV_LAT; end
            end
            OP_MTHI: hiOut_m = a;
            OP_MTLO: loOut_m = a;
            default: ;
        endcase
    endfunction

    // Issues one op, scrambles operands after accept, pokes a stray MTHI mid-operation,
    // then checks done latency, busy length and the final HI/LO.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expHi, input logic [31:0] expLo,
                                 input int expLat, input string name);
        int cyc, busyCnt, doneCyc;
        @(negedge clk);
        start = 1'b1; opIn = op; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0; opIn = 3'($urandom_range(0, 5)); srcA = $urandom; srcB = $urandom;
        cyc = 1; busyCnt = 0; doneCyc = 0;
        if (expLat != 0) begin
            while (cyc <= 60) begin
                if (busy) busyCnt++;
                if (done) begin doneCyc = cyc; break; end
                if (cyc == 5) begin start = 1'b1; opIn = OP_MTHI; end
                if (cyc == 6) start = 1'b0;
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            checkOutput({name, " doneCycle"}, 64'(doneCyc), 64'(expLat));
            checkOutput({name, " busyCycles"}, 64'(busyCnt), 64'(expLat));
            @(negedge clk);
        end
        checkOutput({name, " HI"}, 64'(hiOut), 64'(expHi));
        checkOutput({name, " LO"}, 64'(loOut), 64'(expLo));
        checkOutput({name, " busyAfter"}, 64'(busy), 64'd0);
        checkOutput({name, " doneAfter"}, 64'(done), 64'd0);
        mHi = expHi;
        mLo = expLo;
    endtask

    initial begin
        logic [2:0]  rOp;
        logic [31:0] rA, rB, eHi, eLo;
        int          eLat, doneSeen;

        reset_n = 1'b0; start = 1'b0; opIn = '0; flush = 1'b0; srcA = '0; srcB = '0;
        mHi = '0; mLo = '0;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MULT_LAT, "multNeg"};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MULT_LAT, "multu"};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT,  "divNeg7"};
        vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT,  "divOvf"};
        vecs[4] = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1,        "divZero"};
        vecs[5] = '{OP_MTLO,  32'h12345678, 32'h00000000, 32'h00000064, 32'h12345678, 0,        "mtlo"};
        vecs[6] = '{OP_MTHI,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h12345678, 0,        "mthi"};
        vecs[7] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, DIV_LAT,  "divu100by7"};
        vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULT_LAT, "multMinSq"};

        repeat (3) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset HI", 64'(hiOut), 64'd0);
        checkOutput("reset LO", 64'(loOut), 64'd0);
        reset_n = 1'b1;

        foreach (vecs[i])
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo,
                          vecs[i].expLat, vecs[i].name);

        for (int i = 0; i < 40; i++) begin
            rOp = 3'($urandom_range(0, 5));
            rA  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0:       rB = 32'h0;
                1:       rB = 32'($urandom_range(1, 20));
                2:       rB = -32'($urandom_range(1, 20));
                default: rB = $urandom;
            endcase
            refModel(rOp, rA, rB, mHi, mLo, eHi, eLo, eLat);
            applyStimulus(rOp, rA, rB, eHi, eLo, eLat, $sformatf("rand%0d", i));
        end

        // Flush during the tenth ITER cycle.
        @(negedge clk);
        start = 1'b1; opIn = OP_DIVU; srcA = 32'd1000; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flushIter busy", 64'(busy), 64'd0);
        doneSeen = 0;
        repeat (40) begin
            if (done) doneSeen = 1;
            @(negedge clk);
        end
        checkOutput("flushIter noDone", 64'(doneSeen), 64'd0);
        checkOutput("flushIter HI", 64'(hiOut), 64'(mHi));
        checkOutput("flushIter LO", 64'(loOut), 64'(mLo));

        // Flush coincident with a start in IDLE accepts nothing.
        start = 1'b1; flush = 1'b1; opIn = OP_MTLO; srcA = 32'hAAAA5555;
        @(negedge clk);
        checkOutput("flushStart LO", 64'(loOut), 64'(mLo));
        opIn = OP_MULT; srcA = 32'd3; srcB = 32'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkOutput("flushStart busy", 64'(busy), 64'd0);

        // Flush in FIXUP suppresses done and the HI/LO write.
        @(negedge clk);
        start = 1'b1; opIn = OP_DIVU; srcA = 32'd77; srcB = 32'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("flushFixup doneBefore", 64'(done), 64'd1);
        flush = 1'b1;
        #1;
        checkOutput("flushFixup doneMasked", 64'(done), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flushFixup HI", 64'(hiOut), 64'(mHi));
        checkOutput("flushFixup LO", 64'(loOut), 64'(mLo));
        checkOutput("flushFixup busy", 64'(busy), 64'd0);

        // Reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; opIn = OP_DIV; srcA = 32'hFFFFFFF9; srcB = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midReset busy", 64'(busy), 64'd0);
        checkOutput("midReset done", 64'(done), 64'd0);
        checkOutput("midReset HI", 64'(hiOut), 64'd0);
        checkOutput("midReset LO", 64'(loOut), 64'd0);
        reset_n = 1'b1;
        mHi = '0; mLo = '0;

        applyStimulus(OP_MTLO, 32'h12345678, 32'h0, 32'h0, 32'h12345678, 0, "mtloAfterReset");

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
